// File: rtl/solo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : solo_pkg
// Purpose  : Shared definitions for the solo voice engine: note codes, the
//            Markov transition table, oscillator half-periods (50 MHz clock),
//            LFSR feedback masks for widths 4..16 and the FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package solo_pkg;

    typedef logic [3:0] note_t;

    localparam note_t REST = 4'd0;
    localparam note_t D1   = 4'd1;
    localparam note_t E1   = 4'd2;
    localparam note_t F1   = 4'd3;
    localparam note_t G1   = 4'd4;
    localparam note_t A1   = 4'd5;
    localparam note_t B1   = 4'd6;
    localparam note_t C2   = 4'd7;
    localparam note_t D2   = 4'd8;
    localparam note_t E2   = 4'd9;
    localparam note_t F2   = 4'd10;
    localparam note_t G2   = 4'd11;
    localparam note_t A2   = 4'd12;
    localparam note_t B2   = 4'd13;
    localparam note_t D3   = 4'd14;
    localparam note_t E3   = 4'd15;

    // NOTE_POOL[current][lfsr[3:0]] = next note. Entry 0 of each row sits in
    // the least-significant nibble. Rows favour steps of 1..4 notes, and every
    // pitched row carries one REST so phrases breathe.
    localparam logic [15:0][3:0] NOTE_POOL [16] = '{
        64'h60A3_C815_8FCA_8531,   // REST
        64'h1311_5012_1411_3121,   // D1
        64'h1421_6013_1521_4132,   // E1
        64'h1531_7024_1631_5243,   // F1
        64'h2641_8035_1742_6354,   // G1
        64'h3751_9046_2853_7465,   // A1
        64'h4862_A057_3964_8576,   // B1
        64'h5973_B068_4A75_9687,   // C2
        64'h6A84_C079_5B86_A798,   // D2
        64'h7B95_D08A_6C97_B8A9,   // E2
        64'h8CA6_E09B_7DA8_C9BA,   // F2
        64'h9DB7_F0AC_8EB9_DACB,   // G2
        64'hAEC8_F0BD_9FCA_EBDC,   // A2
        64'hBFD9_F0CE_AFDB_FCED,   // B2
        64'hCFEA_F0DF_BFEC_FDFE,   // D3
        64'hDFFB_F0EF_CFFD_FEFF    // E3
    };

    // Half-period in clock cycles; 0 means silent (REST).
    localparam logic [18:0] HALF_PERIOD [16] = '{
        19'd0,     19'd10641, 19'd9480,  19'd8948,
        19'd7972,  19'd7102,  19'd6327,  19'd5972,
        19'd5321,  19'd4740,  19'd4474,  19'd3986,
        19'd3551,  19'd3164,  19'd2660,  19'd2370
    };

    // Feedback tap mask for a left-shifting Fibonacci LFSR (maximal length).
    function automatic logic [15:0] lfsr_tap_mask(input int width);
        logic [15:0] m;
        case (width)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/solo_voice_engine_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : solo_lfsr
// Purpose  : Note/rhythm pseudo-random source. Left-shifting Fibonacci LFSR
//            with a width-dependent maximal-length tap mask.
// Ports    : clk, rst_n (async, active-low) ; i_load/i_seed load the state
//            (a zero seed loads all-ones so the register never locks up) ;
//            i_step advances one step ; o_state is the current state.
// Revision : 1.0 - initial release
// ============================================================================
module solo_lfsr
#(
    parameter int LFSR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_state
);
    import solo_pkg::*;

    localparam logic [15:0]       c_TAPS_FULL = lfsr_tap_mask(LFSR_W);
    localparam logic [LFSR_W-1:0] c_TAPS      = c_TAPS_FULL[LFSR_W-1:0];

    logic [LFSR_W-1:0] r_state;
    logic              w_fb;

    assign w_fb = ^(r_state & c_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '1;
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? '1 : i_seed;
        end else if (i_step) begin
            r_state <= {r_state[LFSR_W-2:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/solo_voice_engine.sv
`default_nettype none
// ============================================================================
// Module   : solo_voice_engine
// Purpose  : Single-voice melody engine. A Markov note selector driven by an
//            LFSR picks each note, a duration counter sets random note lengths
//            (tempo_period >> 0/1/2), a silent gap separates notes, and a
//            square-wave oscillator produces a signed, registered sample.
// Ports    : CLOCK_50, resetn (async, active-low) ; run, seed, tempo_period,
//            mute in ; sample_out, note_cur, note_strobe, busy out.
// Options  : SOLO_DECAY_EN - per-note amplitude decay (halves every
//            2^DECAY_LOG2 PLAY cycles, at most four halvings).
// Revision : 1.0 - initial release
// ============================================================================
module solo_voice_engine
#(
    parameter int SAMPLE_W   = 32,
    parameter int AMPLITUDE  = 10000000,
    parameter int LFSR_W     = 8,
    parameter int TEMPO_W    = 26,
    parameter int GAP_CYCLES = 50000,
    parameter int DECAY_LOG2 = 20
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                run,
    input  logic [LFSR_W-1:0]   seed,
    input  logic [TEMPO_W-1:0]  tempo_period,
    input  logic                mute,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic [3:0]          note_cur,
    output logic                note_strobe,
    output logic                busy
);
    import solo_pkg::*;

    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [SAMPLE_W-1:0] c_AMP = SAMPLE_W'(AMPLITUDE);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                r_state;
    note_t                 r_note;
    logic [TEMPO_W-1:0]    r_dur;
    logic [c_GAP_W-1:0]    r_gap;
    logic [18:0]           r_phase;
    logic                  r_level;
    logic [SAMPLE_W-1:0]   r_sample;
    logic                  r_strobe;
    logic                  r_busy;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t                w_state_nxt;
    logic                  w_entry;
    note_t                 w_note_nxt;
    logic [TEMPO_W-1:0]    w_dur_nxt;
    logic [c_GAP_W-1:0]    w_gap_nxt;
    logic [18:0]           w_phase_nxt;
    logic                  w_level_nxt;
    logic [SAMPLE_W-1:0]   w_sample_nxt;
    logic [SAMPLE_W-1:0]   w_mag;
    logic                  w_lfsr_load;
    logic                  w_lfsr_step;
    logic [LFSR_W-1:0]     w_lfsr;
    logic [1:0]            w_rsel;
    logic [1:0]            w_rshift;
    logic [TEMPO_W-1:0]    w_tempo_eff;
    logic [TEMPO_W-1:0]    w_len_raw;
    logic [TEMPO_W-1:0]    w_len;
    note_t                 w_note_sel;
    logic [18:0]           w_half_cur;
    logic [18:0]           w_half_nxt;
    logic                  w_lfsr_unused;

    solo_lfsr #(
        .LFSR_W  (LFSR_W)
    ) u_lfsr (
        .clk     (CLOCK_50),
        .rst_n   (resetn),
        .i_load  (w_lfsr_load),
        .i_seed  (seed),
        .i_step  (w_lfsr_step),
        .o_state (w_lfsr)
    );

    // Only the low bits of the LFSR steer note choice and rhythm.
    assign w_lfsr_unused = ^w_lfsr;

    // Rhythm bits exist only when the LFSR is wide enough.
    generate
        if (LFSR_W >= 6) begin : g_rsel_wide
            assign w_rsel = w_lfsr[5:4];
        end else begin : g_rsel_narrow
            assign w_rsel = 2'd0;
        end
    endgenerate

    // Note-entry calculations, using LFSR bits before the step.
    assign w_rshift    = (w_rsel == 2'd3) ? 2'd0 : w_rsel;
    assign w_tempo_eff = (tempo_period == '0) ? TEMPO_W'(1) : tempo_period;
    assign w_len_raw   = w_tempo_eff >> w_rshift;
    assign w_len       = (w_len_raw == '0) ? TEMPO_W'(1) : w_len_raw;
    assign w_note_sel  = NOTE_POOL[r_note][w_lfsr[3:0]];
    assign w_half_cur  = HALF_PERIOD[r_note];
    assign w_half_nxt  = HALF_PERIOD[w_note_nxt];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. w_entry flags every edge that starts a new note.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_entry     = 1'b0;
        if (!run) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_LOAD;
                ST_LOAD: begin
                    w_state_nxt = ST_PLAY;
                    w_entry     = 1'b1;
                end
                ST_PLAY: begin
                    if (r_dur == TEMPO_W'(1)) begin
                        if (GAP_CYCLES == 0) begin
                            w_entry = 1'b1;
                        end else begin
                            w_state_nxt = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == c_GAP_W'(1)) begin
                        w_state_nxt = ST_PLAY;
                        w_entry     = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional decay: shift amount follows cycles spent in the note.
    // ------------------------------------------------------------------
`ifdef SOLO_DECAY_EN
    logic [DECAY_LOG2-1:0] r_dcnt;
    logic [2:0]            r_dshift;
    logic [DECAY_LOG2-1:0] w_dcnt_nxt;
    logic [2:0]            w_dshift_nxt;

    always_comb begin
        w_dcnt_nxt   = '0;
        w_dshift_nxt = '0;
        if (!w_entry && (w_state_nxt == ST_PLAY)) begin
            w_dcnt_nxt   = r_dcnt + DECAY_LOG2'(1);
            w_dshift_nxt = r_dshift;
            if ((r_dcnt == '1) && (r_dshift != 3'd4)) begin
                w_dshift_nxt = r_dshift + 3'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_dcnt   <= '0;
            r_dshift <= '0;
        end else begin
            r_dcnt   <= w_dcnt_nxt;
            r_dshift <= w_dshift_nxt;
        end
    end

    assign w_mag = c_AMP >> w_dshift_nxt;
`else
    assign w_mag = c_AMP;
`endif

    // ------------------------------------------------------------------
    // FSM: outputs / datapath next values. Every output is registered, so
    // the values shown in a cycle are computed from that cycle's next state.
    // ------------------------------------------------------------------
    always_comb begin
        w_note_nxt   = r_note;
        w_dur_nxt    = r_dur;
        w_gap_nxt    = r_gap;
        w_phase_nxt  = '0;
        w_level_nxt  = 1'b1;
        w_lfsr_load  = 1'b0;
        w_lfsr_step  = 1'b0;
        w_sample_nxt = '0;

        if (w_entry) begin
            w_note_nxt  = w_note_sel;
            w_dur_nxt   = w_len;
            w_lfsr_step = 1'b1;
        end else begin
            case (w_state_nxt)
                ST_IDLE: begin
                    w_note_nxt = REST;
                    w_dur_nxt  = '0;
                    w_gap_nxt  = '0;
                end
                ST_LOAD: begin
                    w_note_nxt  = REST;
                    w_lfsr_load = 1'b1;
                end
                ST_PLAY: begin
                    w_dur_nxt = r_dur - TEMPO_W'(1);
                    if (w_half_cur == '0) begin
                        w_level_nxt = r_level;
                    end else if (r_phase == w_half_cur - 19'd1) begin
                        w_level_nxt = ~r_level;
                    end else begin
                        w_phase_nxt = r_phase + 19'd1;
                        w_level_nxt = r_level;
                    end
                end
                ST_GAP: begin
                    w_dur_nxt = '0;
                    w_gap_nxt = (r_state == ST_PLAY) ? c_GAP_W'(GAP_CYCLES)
                                                     : r_gap - c_GAP_W'(1);
                end
                default: w_note_nxt = REST;
            endcase
        end

        if ((w_state_nxt == ST_PLAY) && (w_half_nxt != '0) && !mute) begin
            w_sample_nxt = w_level_nxt ? w_mag : -w_mag;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_note   <= REST;
            r_dur    <= '0;
            r_gap    <= '0;
            r_phase  <= '0;
            r_level  <= 1'b1;
            r_sample <= '0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_note   <= w_note_nxt;
            r_dur    <= w_dur_nxt;
            r_gap    <= w_gap_nxt;
            r_phase  <= w_phase_nxt;
            r_level  <= w_level_nxt;
            r_sample <= w_sample_nxt;
            r_strobe <= w_entry;
            r_busy   <= (w_state_nxt != ST_IDLE);
        end
    end

    assign sample_out  = r_sample;
    assign note_cur    = r_note;
    assign note_strobe = r_strobe;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_solo_voice_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_solo_voice_engine
// Purpose  : Randomised scoreboard bench for solo_voice_engine. A note-level
//            reference model pushes the expected outputs of every clock edge
//            into a queue; a monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_solo_voice_engine;
    import solo_pkg::*;

    localparam int SAMPLE_W   = 32;
    localparam int AMPLITUDE  = 10000000;
    localparam int LFSR_W     = 8;
    localparam int TEMPO_W    = 26;
    localparam int GAP_CYCLES = 10;
    localparam int DECAY_LOG2 = 4;

    logic                clk    = 1'b0;
    logic                resetn = 1'b0;
    logic                run    = 1'b0;
    logic                mute   = 1'b0;
    logic [LFSR_W-1:0]   seed   = '0;
    logic [TEMPO_W-1:0]  tempo  = '0;
    logic [SAMPLE_W-1:0] sample_out;
    logic [3:0]          note_cur;
    logic                note_strobe;
    logic                busy;

    solo_voice_engine #(
        .SAMPLE_W   (SAMPLE_W),
        .AMPLITUDE  (AMPLITUDE),
        .LFSR_W     (LFSR_W),
        .TEMPO_W    (TEMPO_W),
        .GAP_CYCLES (GAP_CYCLES),
        .DECAY_LOG2 (DECAY_LOG2)
    ) u_dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .run          (run),
        .seed         (seed),
        .tempo_period (tempo),
        .mute         (mute),
        .sample_out   (sample_out),
        .note_cur     (note_cur),
        .note_strobe  (note_strobe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SAMPLE_W-1:0] sample;
        logic [3:0]          note;
        logic                strobe;
        logic                busy;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   dut_notes = 0;

    // ------------------------------------------------------------------
    // Reference model: note-level view of the voice.
    // ------------------------------------------------------------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_NOTE = 2, M_GAP = 3;
    int                m_mode = M_IDLE;
    int                m_note = 0;
    int                m_len  = 0;
    int                m_k    = 0;
    int                m_gaps = 0;
    logic [LFSR_W-1:0] m_lfsr = '1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic [15:0] m;
        m = lfsr_tap_mask(LFSR_W);
        return {s[LFSR_W-2:0], ^(s & m[LFSR_W-1:0])};
    endfunction

    // Sample k cycles into a note: square wave starting high, toggling every
    // half-period cycles.
    function automatic logic [SAMPLE_W-1:0] sample_of(input int note, input int k,
                                                      input logic mu);
        int     half;
        longint mag;
        half = int'(HALF_PERIOD[note]);
        if (half == 0 || mu) return '0;
        mag = AMPLITUDE;
`ifdef SOLO_DECAY_EN
        mag = mag >> (((k >> DECAY_LOG2) > 4) ? 4 : (k >> DECAY_LOG2));
`endif
        if (((k / half) % 2) == 1) mag = -mag;
        return mag[SAMPLE_W-1:0];
    endfunction

    function automatic exp_t start_note();
        exp_t e;
        int   r;
        int   tp;
        m_note = int'(NOTE_POOL[m_note][m_lfsr[3:0]]);
        r = (LFSR_W >= 6) ? int'(m_lfsr[5:4]) : 0;
        if (r == 3) r = 0;
        tp = (tempo == 0) ? 1 : int'(tempo);
        m_len = tp >> r;
        if (m_len < 1) m_len = 1;
        m_lfsr = lfsr_next(m_lfsr);
        m_k    = 0;
        m_mode = M_NOTE;
        e.sample = sample_of(m_note, 0, mute);
        e.note   = 4'(m_note);
        e.strobe = 1'b1;
        e.busy   = 1'b1;
        return e;
    endfunction

    initial begin : model
        exp_t e;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_mode = M_IDLE;
                m_note = 0;
                m_lfsr = '1;
                q.delete();
            end else begin
                e = '0;
                if (!run) begin
                    m_mode = M_IDLE;
                    m_note = 0;
                end else begin
                    case (m_mode)
                        M_IDLE: begin
                            m_lfsr = (seed == '0) ? '1 : seed;
                            m_mode = M_LOAD;
                            e.busy = 1'b1;
                        end
                        M_LOAD: e = start_note();
                        M_NOTE: begin
                            if (m_k + 1 < m_len) begin
                                m_k++;
                                e.sample = sample_of(m_note, m_k, mute);
                                e.note   = 4'(m_note);
                                e.busy   = 1'b1;
                            end else if (GAP_CYCLES == 0) begin
                                e = start_note();
                            end else begin
                                m_mode = M_GAP;
                                m_gaps = 1;
                                e.note = 4'(m_note);
                                e.busy = 1'b1;
                            end
                        end
                        default: begin
                            if (m_gaps < GAP_CYCLES) begin
                                m_gaps++;
                                e.note = 4'(m_note);
                                e.busy = 1'b1;
                            end else begin
                                e = start_note();
                            end
                        end
                    endcase
                end
                q.push_back(e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (!resetn) begin
                if (sample_out !== '0 || note_cur !== 4'd0 || note_strobe !== 1'b0 ||
                    busy !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state @%0t: sample %0d note %0d strobe %0b busy %0b, required all zero",
                             $time, $signed(sample_out), note_cur, note_strobe, busy);
                end
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty @%0t: got no expected entry for output", $time);
            end else begin
                e = q.pop_front();
                if ({sample_out, note_cur, note_strobe, busy} !== e) begin
                    errors++;
                    $display("FAIL cycle_out @%0t: sample %0d note %0d strobe %0b busy %0b, required sample %0d note %0d strobe %0b busy %0b",
                             $time, $signed(sample_out), note_cur, note_strobe, busy,
                             $signed(e.sample), e.note, e.strobe, e.busy);
                end
                if (note_strobe === 1'b1) dut_notes++;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [TEMPO_W-1:0] pick_tempo();
        case ($urandom_range(0, 5))
            0:       return TEMPO_W'(0);
            1:       return TEMPO_W'(1);
            2:       return TEMPO_W'(2);
            3:       return TEMPO_W'(3);
            default: return TEMPO_W'($urandom_range(4, 60));
        endcase
    endfunction

    task automatic wait_notes(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (dut_notes < target && c < budget) begin
            tick();
            c++;
        end
        checks++;
        if (dut_notes < target) begin
            errors++;
            $display("FAIL %s: saw %0d note strobes, required at least %0d", tag, dut_notes, target);
        end
    endtask

    initial begin : stim
        // Reset held with run already high; seed 0 must load all-ones.
        run   = 1'b1;
        seed  = '0;
        tempo = TEMPO_W'($urandom_range(0, 20));
        repeat (3) tick();
        resetn = 1'b1;
        wait_notes(64, 6000, "note_count_seed0");
        run = 1'b0;
        repeat (2) tick();

        // Randomised sessions: mute toggling, tempo changes, run drops.
        for (int s = 0; s < 10; s++) begin
            seed  = ($urandom_range(0, 3) == 0) ? '0 : LFSR_W'($urandom);
            tempo = pick_tempo();
            run   = 1'b1;
            for (int c = 0; c < int'($urandom_range(100, 600)); c++) begin
                tick();
                if ($urandom_range(0, 15) == 0) mute = ~mute;
                if ($urandom_range(0, 63) == 0) tempo = pick_tempo();
            end
            run = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        mute = 1'b0;

        // Zero tempo: one-cycle notes back to back with gaps.
        tempo = '0;
        run   = 1'b1;
        repeat (60) tick();
        run = 1'b0;
        tick();

        // Tempo 1000: notes of 1000, 500 or 250 cycles.
        dut_notes = 0;
        seed  = LFSR_W'($urandom);
        tempo = TEMPO_W'(1000);
        run   = 1'b1;
        wait_notes(6, 8000, "note_count_t1000");
        run = 1'b0;
        tick();

        // Long notes so the oscillator toggles several times.
        seed  = LFSR_W'($urandom);
        tempo = TEMPO_W'(12000);
        run   = 1'b1;
        for (int c = 0; c < 30000; c++) begin
            tick();
            if (c % 7000 == 6999) mute = ~mute;
        end
        mute = 1'b0;

        // Asynchronous reset mid-note with run still high.
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tempo  = TEMPO_W'(40);
        repeat (300) tick();
        run = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/solo_voice_engine.md
# solo_voice_engine

Parametrised single-voice melody engine for the audio path: a Markov-chain note selector driven by a configurable-width LFSR, a tempo counter with random note durations, an articulation gap between notes, and a square-wave oscillator producing a signed sample. It sits between the switch/control logic and the adder that mixes its sample into the left/right channel outputs feeding `Audio_Controller`.

## Interface
- `SAMPLE_W`, 32: width of `sample_out` (signed).
- `AMPLITUDE`, 10000000: peak magnitude of the square wave; must fit in `SAMPLE_W-1` bits.
- `LFSR_W`, 8: note/rhythm LFSR width, legal 4..16.
- `TEMPO_W`, 26: width of `tempo_period`.
- `GAP_CYCLES`, 50000: silent cycles between consecutive notes; 0 disables the gap.
- `DECAY_LOG2`, 20: log2 of cycles per decay step (used only with `SOLO_DECAY_EN`).

Ports:
- `CLOCK_50` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `run` in 1: play enable; 0 forces idle.
- `seed` in `LFSR_W`: LFSR load value, sampled in LOAD.
- `tempo_period` in `TEMPO_W`: cycles per full-length note.
- `mute` in 1: forces `sample_out` to 0 without stopping the sequence.
- `sample_out` out `SAMPLE_W`: signed square-wave sample, registered.
- `note_cur` out 4: current note code (0 = REST).
- `note_strobe` out 1: one-cycle pulse when a new note starts.
- `busy` out 1: high in LOAD, PLAY, GAP.

## Operation
- FSM states IDLE, LOAD, PLAY, GAP. Reset and `run`=0 force IDLE.
- IDLE→LOAD when `run`=1. LOAD (1 cycle): LFSR ← `seed` (all-ones if `seed`=0, avoiding lock-up); `note_cur` stays REST.
- LOAD→PLAY and GAP→PLAY: `note_cur` ← `NOTE_POOL[note_cur][lfsr[3:0]]`; LFSR advances one step; duration counter loaded with `max(tempo_period,1) >> r`, r = `lfsr[5:4]` with 3 mapped to 0 (lfsr bits taken before the step; for `LFSR_W`<6, r = 0); `note_strobe`=1.
- PLAY: duration counter decrements each cycle; at 1 → GAP (or straight to next PLAY entry if `GAP_CYCLES`=0).
- GAP: `sample_out`=0, counts `GAP_CYCLES` then PLAY.
- Oscillator: half-period `HALF_PERIOD[note_cur]`; phase counter counts 0..half-1, toggles level at wrap. Note entry resets phase to 0 and level to positive. Half-period 0 (REST) → `sample_out`=0, phase held at 0.
- `sample_out` = level ? +`AMPLITUDE` : −`AMPLITUDE`, sign-extended to `SAMPLE_W`; 0 when IDLE, LOAD, GAP, REST, or `mute`.
- `run` falling mid-note: next cycle IDLE, `note_cur`=REST, `sample_out`=0, counters cleared. `tempo_period` change takes effect at the next note entry only.

## Timing
- Reset values: `sample_out`=0, `note_cur`=0, `note_strobe`=0, `busy`=0; LFSR all-ones; FSM IDLE.
- `run` sampled high at edge N → LOAD at N+1 → PLAY with `note_strobe` at N+2.
- Note length in PLAY exactly `max(tempo_period,1) >> r` cycles (min 1); one GAP of `GAP_CYCLES` follows.
- Square wave: first toggle `half` cycles after note entry; period 2·`half`.
- All outputs registered; `mute` affects `sample_out` one cycle later.

## Configuration
- `SOLO_DECAY_EN` defined: per-note shift counter cleared at note entry, incremented every 2^`DECAY_LOG2` cycles in PLAY, saturating at 4; magnitude = `AMPLITUDE >> shift`.
- Undefined: magnitude constant `AMPLITUDE`; no decay counter logic.

## Structure
- Package `solo_pkg`: note code constants (REST, D1…E3), `NOTE_POOL[16][16]` transition table (16 entries per note, REST row included), `HALF_PERIOD[16]` (19-bit, REST = 0), LFSR tap masks per width 4..16, FSM state enum.
- Sub-module `solo_lfsr` (parameter `LFSR_W`; load, step, state out). Oscillator, duration counter, FSM stay in the top.

## Test plan
- Reset with `run`=1: release `resetn` → `sample_out`=0 and `busy`=0 during reset; `note_strobe` exactly 2 cycles after first sampled `run`.
- `seed`=0, `LFSR_W`=8 → LFSR loads 8'hFF; note sequence matches reference model for 64 notes.
- `tempo_period`=1000, `GAP_CYCLES`=10 → each PLAY lasts 1000, 500 or 250 cycles per r, followed by 10 zero samples; `tempo_period`=0 → 1-cycle notes.
- Note with `HALF_PERIOD`=4 → `sample_out` = +10000000 for 4 cycles, −10000000 for 4, repeating; REST → constant 0.
- `run` dropped mid-PLAY → next cycle `note_cur`=0, `sample_out`=0, `busy`=0; `mute`=1 → zeros while `note_strobe` continues.
- With `SOLO_DECAY_EN`, `DECAY_LOG2`=4 → magnitude 10000000, 5000000, … every 16 cycles, floor 625000.
